// File: rtl/conv_encoder_tx.sv
// ---------------------------------------------------------------------------
// conv_encoder_tx
// Framed rate-1/2, K=3 convolutional encoder (4-state trellis). Each accepted
// data bit produces one 2-bit code symbol. With TAIL_EN=1, K-1 zero tail bits
// are appended to every frame, so the trellis ends each frame in S0.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous reset, active low
//   i_start      frame start request (sampled in IDLE only)
//   i_bit        data bit
//   i_valid      i_bit valid
//   o_ready      encoder accepts i_bit this cycle
//   o_code       code symbol {c0,c1}: [1]=G0 parity, [0]=G1 parity
//   o_valid      o_code valid
//   i_ready      downstream accepts o_code this cycle
//   o_last       o_code is the final symbol of the frame
//   o_state      trellis state {s1,s0} after the last consumed bit
//   o_busy       FSM not idle or output register occupied
//   o_frame_done one-cycle pulse after the last symbol is handed off
// ---------------------------------------------------------------------------
module conv_encoder_tx #(
    parameter int         FRAME_LEN = 16,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101,
    parameter bit         TAIL_EN   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_bit,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [1:0] o_code,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_last,
    output logic [1:0] o_state,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ENCODE = 2'b01,
        ST_TAIL   = 2'b10
    } state_e;

    function automatic logic parity3(input logic [2:0] v);
        return ^v;
    endfunction

    // u = {b, s1, s0}; each output bit is the parity of the tapped positions
    function automatic logic [1:0] encode_sym(input logic b, input logic [1:0] sr);
        logic [2:0] u;
        u = {b, sr};
        return {parity3(G0 & u), parity3(G1 & u)};
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tail_q, tail_d;
    logic [1:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    logic             slot_free_s;
    logic             ready_s;
    logic             load_s;
    logic             bit_s;
    logic             last_sym_s;

    // Next-state, handshake and output-register update logic
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        tail_d      = tail_q;
        code_d      = code_q;
        last_d      = last_q;
        // Symbol leaves on handoff unless replaced by a new load below
        valid_d     = valid_q & ~i_ready;
        done_d      = valid_q & i_ready & last_q;
        slot_free_s = ~valid_q | i_ready;
        ready_s     = 1'b0;
        load_s      = 1'b0;
        bit_s       = 1'b0;
        last_sym_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_ENCODE;
                    sreg_d  = 2'b00;
                    cnt_d   = '0;
                    tail_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENCODE: begin
                ready_s = slot_free_s;
                if (i_valid && slot_free_s) begin
                    load_s = 1'b1;
                    bit_s  = i_bit;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        if (TAIL_EN) begin
                            state_d = ST_TAIL;
                            tail_d  = 1'b0;
                        end else begin
                            state_d    = ST_IDLE;
                            last_sym_s = 1'b1;
                        end
                    end else begin
                        state_d = ST_ENCODE;
                    end
                end else begin
                    state_d = ST_ENCODE;
                end
            end
            ST_TAIL: begin
                // Zero tail bits are consumed whenever the output slot is free
                if (slot_free_s) begin
                    load_s = 1'b1;
                    bit_s  = 1'b0;
                    if (tail_q) begin
                        state_d    = ST_IDLE;
                        last_sym_s = 1'b1;
                    end else begin
                        tail_d = 1'b1;
                    end
                end else begin
                    state_d = ST_TAIL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            code_d  = encode_sym(bit_s, sreg_q);
            last_d  = last_sym_s;
            valid_d = 1'b1;
            sreg_d  = {bit_s, sreg_q[1]};
        end else begin
            code_d = code_q;
        end
    end

    // State, trellis and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= 2'b00;
            cnt_q   <= '0;
            tail_q  <= 1'b0;
            code_q  <= 2'b00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            tail_q  <= tail_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign o_ready      = ready_s;
    assign o_code       = code_q;
    assign o_valid      = valid_q;
    assign o_last       = last_q;
    assign o_state      = sreg_q;
    assign o_busy       = (state_q != ST_IDLE) | valid_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder_tx
// Three encoder instances: FRAME_LEN=4 with tail, FRAME_LEN=16 with tail,
// FRAME_LEN=4 without tail. Known frames come from a vector table; a random
// back-to-back run is compared with a convolution model and a loopback
// decode of the produced symbols.
// ---------------------------------------------------------------------------
module tb_conv_encoder_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_i, bit_i, valid_i, ready_i;
    logic [2:0] ready_o, valid_o, last_o, busy_o, done_o;
    logic [5:0] code_o, state_o;

    always #5 clk = ~clk;

    conv_encoder_tx #(.FRAME_LEN(4), .TAIL_EN(1'b1)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_i[0]), .i_bit(bit_i[0]),
        .i_valid(valid_i[0]), .o_ready(ready_o[0]), .o_code(code_o[1:0]),
        .o_valid(valid_o[0]), .i_ready(ready_i[0]), .o_last(last_o[0]),
        .o_state(state_o[1:0]), .o_busy(busy_o[0]), .o_frame_done(done_o[0]));

    conv_encoder_tx #(.FRAME_LEN(16), .TAIL_EN(1'b1)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_i[1]), .i_bit(bit_i[1]),
        .i_valid(valid_i[1]), .o_ready(ready_o[1]), .o_code(code_o[3:2]),
        .o_valid(valid_o[1]), .i_ready(ready_i[1]), .o_last(last_o[1]),
        .o_state(state_o[3:2]), .o_busy(busy_o[1]), .o_frame_done(done_o[1]));

    conv_encoder_tx #(.FRAME_LEN(4), .TAIL_EN(1'b0)) u_dut4nt (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_i[2]), .i_bit(bit_i[2]),
        .i_valid(valid_i[2]), .o_ready(ready_o[2]), .o_code(code_o[5:4]),
        .o_valid(valid_o[2]), .i_ready(ready_i[2]), .o_last(last_o[2]),
        .o_state(state_o[5:4]), .o_busy(busy_o[2]), .o_frame_done(done_o[2]));

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] bits;
        int          nbits;
        int          nsym;
        logic [35:0] codes;
        logic [35:0] states;
        bit          stall;
    } vec_t;

    vec_t        tbl[5];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          act    = 0;
    int          done_cnt = 0;
    logic [4:0]  obs_q[$];   // {code[1:0], last, state[1:0]}
    logic [19:0] rbits;

    // Collect every handed-off symbol and frame_done pulse of the active instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o[act] && ready_i[act])
                obs_q.push_back({code_o[act*2 +: 2], last_o[act], state_o[act*2 +: 2]});
            if (done_o[act])
                done_cnt++;
        end
    end

    task automatic check(input string name, input int got, input int exp_v);
        n_chk++;
        if (got == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    endtask

    task automatic wait_ready(input int sel);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready_o[sel] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!ready_o[sel]) check("ready_timeout", 0, 1);
    endtask

    task automatic send_bit(input int sel, input logic b);
        bit_i[sel]   = b;
        valid_i[sel] = 1'b1;
        wait_ready(sel);
        @(posedge clk); #1;
        valid_i[sel] = 1'b0;
    endtask

    task automatic start_frame(input int sel);
        @(posedge clk); #1;
        start_i[sel] = 1'b1;
        @(posedge clk); #1;
        start_i[sel] = 1'b0;
    endtask

    // Hold i_ready low for 3 cycles once the 2nd symbol is on o_code
    task automatic stall_seq(input int sel, input int base);
        int t;
        t = 0;
        while (!((obs_q.size() - base == 1) && valid_o[sel]) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("stall_sync", obs_q.size() - base, 1);
        ready_i[sel] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_code_held", int'(code_o[sel*2 +: 2]), 2);
            check("stall_o_ready", int'(ready_o[sel]), 0);
            check("stall_o_valid", int'(valid_o[sel]), 1);
        end
        @(posedge clk); #1;
        ready_i[sel] = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int base, dbase, t;
        base  = obs_q.size();
        dbase = done_cnt;
        act   = v.sel;
        start_frame(v.sel);
        fork
            begin
                for (int i = 0; i < v.nbits; i++) send_bit(v.sel, v.bits[i]);
            end
            begin
                if (v.stall) stall_seq(v.sel, base);
            end
        join
        t = 0;
        while (done_cnt == dbase && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check($sformatf("%s nsym", v.name), obs_q.size() - base, v.nsym);
        for (int i = 0; i < v.nsym && base + i < obs_q.size(); i++) begin
            check($sformatf("%s code[%0d]", v.name, i), int'(obs_q[base+i][4:3]), int'(v.codes[2*i +: 2]));
            check($sformatf("%s last[%0d]", v.name, i), int'(obs_q[base+i][2]), (i == v.nsym - 1) ? 1 : 0);
            check($sformatf("%s state[%0d]", v.name, i), int'(obs_q[base+i][1:0]), int'(v.states[2*i +: 2]));
        end
        check($sformatf("%s frame_done", v.name), done_cnt - dbase, 1);
        check($sformatf("%s end_state", v.name), int'(state_o[v.sel*2 +: 2]), int'(v.states[2*(v.nsym-1) +: 2]));
        check($sformatf("%s end_busy", v.name), int'(busy_o[v.sel]), 0);
    endtask

    task automatic check_all_zero(input string tag, input int sel);
        check($sformatf("%s o_code", tag), int'(code_o[sel*2 +: 2]), 0);
        check($sformatf("%s o_valid", tag), int'(valid_o[sel]), 0);
        check($sformatf("%s o_last", tag), int'(last_o[sel]), 0);
        check($sformatf("%s o_ready", tag), int'(ready_o[sel]), 0);
        check($sformatf("%s o_busy", tag), int'(busy_o[sel]), 0);
        check($sformatf("%s o_frame_done", tag), int'(done_o[sel]), 0);
        check($sformatf("%s o_state", tag), int'(state_o[sel*2 +: 2]), 0);
    endtask

    // Input bit n of random frame f; zero before the frame and in the tail
    function automatic int ubit(input int f, input int n);
        if (n < 0 || n >= 4) return 0;
        return int'(rbits[4*f + n]);
    endfunction

    task automatic random_test();
        int base, dbase, t, u0, u1, u2, idx;
        base  = obs_q.size();
        dbase = done_cnt;
        act   = 0;
        for (int i = 0; i < 20; i++) rbits[i] = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start_i[0] = 1'b1;
        fork
            begin : feed_blk
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send_bit(0, rbits[i]);
                end
                start_i[0] = 1'b0;
            end
            begin : rdy_blk
                int c;
                c = 0;
                while (obs_q.size() - base < 30 && c < 3000) begin
                    @(posedge clk); #1;
                    ready_i[0] = ($urandom_range(0, 3) != 0);
                    c++;
                end
                ready_i[0] = 1'b1;
            end
        join
        t = 0;
        while (done_cnt - dbase < 5 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check("rand nsym", obs_q.size() - base, 30);
        check("rand frame_done", done_cnt - dbase, 5);
        if (obs_q.size() - base >= 30) begin
            for (int f = 0; f < 5; f++) begin
                for (int n = 0; n < 6; n++) begin
                    idx = base + 6*f + n;
                    u0  = ubit(f, n);
                    u1  = ubit(f, n - 1);
                    u2  = ubit(f, n - 2);
                    check($sformatf("rand f%0d c0[%0d]", f, n), int'(obs_q[idx][4]), u0 ^ u1 ^ u2);
                    check($sformatf("rand f%0d c1[%0d]", f, n), int'(obs_q[idx][3]), u0 ^ u2);
                    check($sformatf("rand f%0d last[%0d]", f, n), int'(obs_q[idx][2]), (n == 5) ? 1 : 0);
                    check($sformatf("rand f%0d state[%0d]", f, n), int'(obs_q[idx][1:0]), 2*u0 + u1);
                end
                // c0^c1 of symbol k+1 equals input bit k
                for (int k = 0; k < 4; k++) begin
                    idx = base + 6*f + k + 1;
                    check($sformatf("loopback f%0d bit%0d", f, k),
                          int'(obs_q[idx][4] ^ obs_q[idx][3]), int'(rbits[4*f + k]));
                end
            end
        end
    endtask

    initial begin
        tbl[0] = '{"case1", 0, 16'h000D, 4, 6,
                   36'({2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11}),
                   36'({2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd2}), 1'b0};
        tbl[1] = '{"case2_stall", 0, 16'h000D, 4, 6,
                   36'({2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11}),
                   36'({2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd2}), 1'b1};
        tbl[2] = '{"case3_zeros", 1, 16'h0000, 16, 18, 36'd0, 36'd0, 1'b0};
        tbl[3] = '{"case3_ones", 1, 16'hFFFF, 16, 18,
                   {2'b11, 2'b01, {14{2'b10}}, 2'b01, 2'b11},
                   {2'd0, 2'd1, {14{2'd3}}, 2'd3, 2'd2}, 1'b0};
        tbl[4] = '{"case5_notail", 2, 16'h000D, 4, 4,
                   36'({2'b01, 2'b00, 2'b10, 2'b11}),
                   36'({2'd3, 2'd2, 2'd1, 2'd2}), 1'b0};

        rst_n   = 1'b0;
        start_i = 3'b000;
        bit_i   = 3'b000;
        valid_i = 3'b000;
        ready_i = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) check_all_zero($sformatf("reset dut%0d", s), s);
        @(negedge clk);
        rst_n = 1'b1;

        for (int e = 0; e < 5; e++) run_vec(tbl[e]);

        // Reset mid-frame after two bits, then re-run case 1 from S0
        act = 0;
        start_frame(0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        check("midframe busy", int'(busy_o[0]), 1);
        check("midframe state", int'(state_o[1:0]), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midframe_reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(tbl[0]);

        random_test();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
